// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one block-wide memory between the icache refill
// port and the dcache refill/writeback port, with a start-timeout error flag.
module mem_arbiter #(
    parameter int ADDR_W        = 28,
    parameter int DATA_W        = 128,
    parameter int START_TIMEOUT = 15
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_ack,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ack,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_writedata,
    input  logic [DATA_W-1:0] mem_readdata,
    input  logic              mem_busywait,
    output logic              err
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    localparam logic OWN_I = 1'b0;
    localparam logic OWN_D = 1'b1;

    localparam int CNT_W = $clog2(START_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(START_TIMEOUT - 1);

    logic [1:0]        state;
    logic              owner;
    logic              last_grant;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] i_rdata_q;
    logic [DATA_W-1:0] d_rdata_q;
    logic [CNT_W-1:0]  cnt;
    logic              err_q;

    logic grant_valid;
    logic grant_d;

    // On a tie the port that did not win last time gets the memory.
    always_comb begin
        grant_valid = i_req | d_req;
        if (i_req && d_req) begin
            grant_d = (last_grant == OWN_I);
        end else begin
            grant_d = d_req;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state      <= IDLE;
            owner      <= OWN_I;
            last_grant <= OWN_I;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            i_rdata_q  <= '0;
            d_rdata_q  <= '0;
            cnt        <= '0;
            err_q      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_valid) begin
                        owner  <= grant_d;
                        we_q   <= grant_d & d_we;
                        addr_q <= grant_d ? d_addr : i_addr;
                        if (grant_d) begin
                            wdata_q <= d_wdata;
                        end
                        state <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (mem_busywait) begin
                        state <= WAIT;
                    end else if (cnt == CNT_LAST) begin
                        // Memory never accepted the strobe: still ack, with zero data on a read.
                        err_q <= 1'b1;
                        if (!we_q) begin
                            if (owner == OWN_D) begin
                                d_rdata_q <= '0;
                            end else begin
                                i_rdata_q <= '0;
                            end
                        end
                        state <= DONE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                WAIT: begin
                    if (!mem_busywait) begin
                        if (!we_q) begin
                            if (owner == OWN_D) begin
                                d_rdata_q <= mem_readdata;
                            end else begin
                                i_rdata_q <= mem_readdata;
                            end
                        end
                        state <= DONE;
                    end
                end
                DONE: begin
                    last_grant <= owner;
                    cnt        <= '0;
                    state      <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    logic strobe;

    // Strobes cover ISSUE and WAIT only, so every transfer is one clean window.
    always_comb begin
        strobe        = (state == ISSUE) || (state == WAIT);
        mem_read      = strobe & ~we_q;
        mem_write     = strobe & we_q;
        mem_address   = addr_q;
        mem_writedata = wdata_q;
        i_ack         = (state == DONE) && (owner == OWN_I);
        d_ack         = (state == DONE) && (owner == OWN_D);
        i_rdata       = i_rdata_q;
        d_rdata       = d_rdata_q;
        err           = err_q;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single block-wide backing memory between the instruction-cache refill port and the data-cache refill/writeback port.
- Selects one requester with round-robin priority and drives the memory's read/write/address/data lines.
- Tracks the memory busywait handshake and returns block data with a one-cycle acknowledge to the winning cache.
- Sits between icache/dcache and the memory model; each cache's controller FSM holds its request until acknowledged.

Parameters:
ADDR_W, 28, block address width (byte address bits [31:4])
DATA_W, 128, block width (4 x 32-bit words)
START_TIMEOUT, 15, max cycles in ISSUE waiting for mem_busywait to rise before flagging an error

Ports:
clock  input  1  single clock, all state updates on posedge
reset  input  1  synchronous, active-low reset
i_req  input  1  icache block-read request, held until i_ack
i_addr  input  ADDR_W  icache block address
i_rdata  output  DATA_W  block returned to icache
i_ack  output  1  one-cycle pulse, i_rdata valid
d_req  input  1  dcache request, held until d_ack
d_we  input  1  1 = block write, 0 = block read
d_addr  input  ADDR_W  dcache block address
d_wdata  input  DATA_W  writeback block
d_rdata  output  DATA_W  block returned to dcache
d_ack  output  1  one-cycle pulse, d_rdata valid (read) or write committed
mem_read  output  1  memory read strobe
mem_write  output  1  memory write strobe
mem_address  output  ADDR_W  memory block address
mem_writedata  output  DATA_W  memory write block
mem_readdata  input  DATA_W  memory read block
mem_busywait  input  1  memory busy; a transfer is complete when it falls after having risen
err  output  1  sticky start-timeout flag

Behaviour:
- Reset (reset==0 at posedge): state=IDLE; last_grant=I, so dcache wins the first tie; timeout counter=0. Outputs i_ack, d_ack, mem_read, mem_write, err = 0. mem_address, mem_writedata, i_rdata, d_rdata = 0. Reset mid-transfer aborts with no ack; the caches restart their requests.
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - No strobes.
  - If exactly one req is high, grant it.
  - If both are high, grant the one not equal to last_grant.
  - On grant, register grant owner, address, we, and wdata; go to ISSUE.
  - Requests sampled in IDLE at cycle N produce mem_read/mem_write high in cycle N+1.
- ISSUE:
  - Strobe high: mem_read = !(owner==D && we); mem_write = owner==D && we. Address and data held from registers.
  - mem_busywait==1 -> go to WAIT.
  - Otherwise increment the counter. When the counter reaches START_TIMEOUT, set err=1 and go to DONE. The ack is still given and rdata = 0 for a read.
- WAIT:
  - Strobe held high.
  - mem_busywait==0 -> capture mem_readdata into the owner's rdata register (reads only) and go to DONE.
- DONE:
  - Strobes low for exactly one cycle.
  - Owner's ack = 1; update last_grant = owner; clear the counter; go to IDLE.
  - Non-owner ack stays 0. Non-owner rdata is unchanged.
- Minimum turnaround: the arbiter returns to IDLE the cycle after DONE. A request held across DONE is re-arbitrated in that IDLE cycle, so there are no back-to-back grants without an IDLE cycle.
- Requests changing while not in IDLE are ignored. Inputs are latched only at grant.
- Deassertion of a request before its ack is a protocol violation; the transfer still completes and acks.
- i_rdata/d_rdata hold their value until the next completed read for that port.
- mem_read and mem_write are never high together; both are low in IDLE and DONE.
- err clears only on reset.
- Starvation bound: a held request is granted after at most one transfer of the other port.

Test Plan:
- Memory model: busywait rises 1 cycle after the strobe and stays high 4 cycles.
  - i_req=1, i_addr=28'h0000012 alone -> mem_read=1 the next cycle, mem_address=28'h0000012.
  - i_ack pulses once 7 cycles after the request, with i_rdata = model block.
  - d_ack stays 0.
- Reset tie: i_req and d_req rise in the same cycle after reset -> dcache granted first (d_ack), then icache (i_ack). Both held continuously -> grants alternate D, I, D, I.
- Write: d_req=1, d_we=1, d_addr=28'h00000A5, d_wdata=128'hDEAD... -> mem_write=1, mem_read=0, mem_writedata matches. d_ack pulses, d_rdata unchanged, model stores the block.
- Timeout: memory never raises busywait, i_req held -> after START_TIMEOUT (15) cycles in ISSUE, err=1, i_ack pulses with i_rdata=0. err remains 1 until reset.
- Reset mid-transfer: assert reset=0 during WAIT -> next posedge: state IDLE, all strobes and acks 0, rdata=0. On release, the re-held request is served normally.
- Protocol invariants across 1000 random req/we/latency cycles:
  - mem_read and mem_write are never high together.
  - Every ack is preceded by exactly one strobe window.
  - Acks never overlap.
